// File: rtl/div_mult_pkg.sv
// Shared encodings and sign helpers for the iterative multiply/divide unit.
// The CPU control unit imports this package for the op encoding as well.
package div_mult_pkg;

  localparam int ITER  = 32;
  localparam int MAX_W = 2 * ITER;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negation; wraps, so the most negative value maps to itself.
  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  // Absolute value of a sign-extended operand.
  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_mult_unit.sv
// Iterative signed MULT/DIV unit: one radix-2 step per clock on operand
// magnitudes, followed by a single sign-correction cycle.
//
//   state | meaning
//   IDLE  | waiting for start; operands and signs latched on acceptance
//   RUN   | one shift-add / restoring-divide step per cycle, cnt counts down
//   FIX   | sign correction applied, hi/lo registered on the way out
//   DONE  | done pulse, hi/lo valid; also the direct target for divide by zero
import div_mult_pkg::*;

module div_mult_unit #(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             busy,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic               is_div, neg_q, neg_r;

  logic               accept, zero_div;
  logic [MAX_W-1:0]   a_mag64, b_mag64;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_nxt;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic [MAX_W-1:0]   prod_neg, quo_neg, rem_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               unused_hi_bits;

  assign accept   = (state == IDLE) && start;
  assign zero_div = accept && (op == OP_DIV) && (b == '0);

  // Operand magnitudes, sign-extended to the helper width first.
  always_comb begin
    a_mag64 = magnitude(MAX_W'($signed(a)));
    b_mag64 = magnitude(MAX_W'($signed(b)));
  end

  // One iteration of shift-add multiply and restoring divide on the accumulator.
  always_comb begin
    mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    mult_nxt = {mult_sum, acc[WIDTH-1:1]};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = rem_sh - {1'b0, mag_b};
    div_nxt  = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction of the finished magnitudes; negation wraps, so
  // MIN / -1 yields MIN with no special case.
  always_comb begin
    prod_neg = negate(MAX_W'(acc));
    quo_neg  = negate(MAX_W'(acc[WIDTH-1:0]));
    rem_neg  = negate(MAX_W'(acc[2*WIDTH-1:WIDTH]));
    prod_fix = neg_q ? prod_neg[2*WIDTH-1:0] : acc;
    quo_fix  = neg_q ? quo_neg[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? rem_neg[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
  end

  assign unused_hi_bits = ^{a_mag64[MAX_W-1:WIDTH], b_mag64[MAX_W-1:WIDTH],
                            quo_neg[MAX_W-1:WIDTH], rem_neg[MAX_W-1:WIDTH]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (zero_div)   state_nxt = DONE;
        else if (start) state_nxt = RUN;
      end
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    done = (state == DONE);
    busy = (state != IDLE);
  end

  // Datapath: latch on acceptance, iterate in RUN, publish results in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      div0   <= 1'b0;
      acc    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div0   <= zero_div;
            mag_a  <= a_mag64[WIDTH-1:0];
            mag_b  <= b_mag64[WIDTH-1:0];
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            is_div <= (op == OP_DIV);
            cnt    <= CW'(WIDTH - 1);
            acc    <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a_mag64[WIDTH-1:0] : b_mag64[WIDTH-1:0])};
          end
        end
        RUN: begin
          acc <= is_div ? div_nxt : mult_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
